// File: rtl/data_mem_mmio.sv
// Data-side memory responder for the pipelined MIPS core: word RAM with zero-latency reads
// plus an MMIO page (cycle counter, TOHOST/done, committed-store counter, sticky misalign error).
module data_mem_mmio #(
    parameter int          DEPTH_LOG2 = 6,
    parameter              INIT_FILE  = "",
    parameter logic [15:0] MMIO_PAGE  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    output logic [31:0] read_data,
    output logic        done,
    output logic [31:0] tohost,
    output logic        misalign_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] r_ram [DEPTH];
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_tohost;
    logic [31:0] r_store_cnt;
    logic        r_done;
    logic        r_misalign_err;

    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_is_mmio;
    logic                  w_reg_hit;
    logic [1:0]            w_reg_sel;
    logic                  w_aligned;
    logic                  w_store_ok;
    logic                  w_ram_we;
    logic                  w_tohost_we;
    logic                  w_err_clr;

    // Upper RAM address bits are ignored, so the RAM aliases every DEPTH words.
    assign w_index     = addr[DEPTH_LOG2+1:2];
    assign w_is_mmio   = (addr[31:16] == MMIO_PAGE);
    assign w_reg_hit   = (addr[15:4] == 12'h000);
    assign w_reg_sel   = addr[3:2];
    assign w_aligned   = (addr[1:0] == 2'b00);
    assign w_store_ok  = mem_write && w_aligned;
    assign w_ram_we    = w_store_ok && !w_is_mmio;
    assign w_tohost_we = w_store_ok && w_is_mmio && w_reg_hit && (w_reg_sel == 2'd1);
    assign w_err_clr   = w_store_ok && w_is_mmio && w_reg_hit && (w_reg_sel == 2'd3)
                         && write_data[0];

    always_comb begin
        read_data = '0;
        if (w_is_mmio) begin
            if (w_reg_hit) begin
                case (w_reg_sel)
                    2'd0:    read_data = r_cycle_cnt;
                    2'd1:    read_data = r_tohost;
                    2'd2:    read_data = r_store_cnt;
                    default: read_data = {31'b0, r_misalign_err};
                endcase
            end
        end else begin
            read_data = r_ram[w_index];
        end
    end

    // RAM contents survive reset; only the write enable is held off while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst && w_ram_we) begin
            r_ram[w_index] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt    <= '0;
            r_tohost       <= '0;
            r_store_cnt    <= '0;
            r_done         <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_ram_we && (r_store_cnt != 32'hFFFF_FFFF)) begin
                r_store_cnt <= r_store_cnt + 32'd1;
            end
            if (w_tohost_we) begin
                r_tohost <= write_data;
                r_done   <= 1'b1;
            end
            // A misaligned store always sets the flag, even when it targets ERR.
            if (mem_write && !w_aligned) begin
                r_misalign_err <= 1'b1;
            end else if (w_err_clr) begin
                r_misalign_err <= 1'b0;
            end
        end
    end

    assign done         = r_done;
    assign tohost       = r_tohost;
    assign misalign_err = r_misalign_err;

endmodule
